bus_uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 30 +++
 rtl/bus_uart_tx_if.sv | 20 ++
 rtl/bus_uart_tx_sync_fifo.sv | 60 ++++++
 rtl/bus_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and transmit FSM state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_MSB = 8;

  // Register byte 0 travels on bus lane 3 (bits [31:24]) and vice versa.
  localparam int LANE3_LSB = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [31:0] lane_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU data-bus slice seen by the UART: address, write data, byte mask,
// write strobe, and the combinational read-back path.
interface bus_uart_tx_if;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  byte_mask;
  logic        mem_write;
  logic [31:0] read_data;
  logic        sel;

  modport master (
    output mem_address, mem_write_data, byte_mask, mem_write,
    input  read_data, sel
  );

  modport slave (
    input  mem_address, mem_write_data, byte_mask, mem_write,
    output read_data, sel
  );
endinterface

// File: rtl/bus_uart_tx_sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an explicit occupancy count.
// A push into a full FIFO is ignored even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == FULL_COUNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TXDATA/STATUS/BAUDDIV
// registers, TX FIFO and the serialising FSM.
//
// state | meaning
// IDLE  | line high; pops the next byte as soon as the FIFO is non-empty
// START | start bit (line low) for DIV cycles
// DATA  | 8 data bits LSB first, DIV cycles each
// STOP  | stop bit (line high) for DIV cycles
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic          clk,
  input  logic          reset,
  bus_uart_tx_if.slave  bus,
  output logic          tx,
  output logic          irq_empty
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            w_sel;
  logic [1:0]      w_off;
  logic            w_wr;
  logic            w_push;
  logic            w_ovf_set;
  logic            w_ovf_clr;
  logic [31:0]     w_status;
  logic [31:0]     w_reg_rd;
  logic            w_unused;

  logic [15:0]     r_bauddiv;
  logic            r_ovf;
  logic [15:0]     w_div_m1;

  logic [7:0]      w_fifo_data;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;

  tx_state_t       r_state;
  tx_state_t       w_state_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [15:0]     r_baud;
  logic [15:0]     w_baud_nxt;
  logic            r_tx;
  logic            w_tx_nxt;
  logic            w_pop;

  assign w_sel = (bus.mem_address[31:4] == BASE_ADDR[31:4]);
  assign w_off = bus.mem_address[3:2];
  assign w_wr  = bus.mem_write & w_sel;

  assign w_push    = w_wr & (w_off == REG_TXDATA) & bus.byte_mask[3];
  assign w_ovf_set = w_push & w_full;
  assign w_ovf_clr = w_wr & (w_off == REG_STATUS) & bus.byte_mask[3]
                   & bus.mem_write_data[LANE3_LSB + ST_OVF];

  assign w_unused = ^{bus.mem_address[1:0], bus.mem_write_data[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bauddiv <= DEFAULT_DIV;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr && (w_off == REG_BAUDDIV)) begin
        if (bus.byte_mask[3]) r_bauddiv[7:0]  <= bus.mem_write_data[31:24];
        if (bus.byte_mask[2]) r_bauddiv[15:8] <= bus.mem_write_data[23:16];
      end
      // A drop on the same edge as a clear must leave the flag set.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.mem_write_data[31:24]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status                          = '0;
    w_status[ST_FULL]                 = w_full;
    w_status[ST_EMPTY]                = w_empty;
    w_status[ST_BUSY]                 = (r_state != IDLE);
    w_status[ST_OVF]                  = r_ovf;
    w_status[ST_CNT_MSB:ST_CNT_LSB]   = 5'(w_count);
  end

  always_comb begin
    w_reg_rd = '0;
    case (w_off)
      REG_STATUS:  w_reg_rd = w_status;
      REG_BAUDDIV: w_reg_rd = {16'h0000, r_bauddiv};
      default:     w_reg_rd = '0;
    endcase
  end

  assign bus.read_data = w_sel ? lane_swap(w_reg_rd) : 32'h0000_0000;
  assign bus.sel       = w_sel;

  // A divisor of zero behaves as one cycle per bit.
  assign w_div_m1 = (r_bauddiv == 16'd0) ? 16'd0 : (r_bauddiv - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_nxt;
      r_baud    <= w_baud_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_idx;
    w_baud_nxt  = r_baud;
    w_tx_nxt    = r_tx;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_data;
          w_bit_nxt   = 3'd0;
          w_baud_nxt  = w_div_m1;
          w_tx_nxt    = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (r_baud == 16'd0) begin
          w_baud_nxt  = w_div_m1;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = DATA;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      DATA: begin
        if (r_baud == 16'd0) begin
          w_baud_nxt = w_div_m1;
          if (r_bit_idx == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_bit_nxt   = r_bit_idx + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      STOP: begin
        if (r_baud == 16'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt = r_baud - 16'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign tx        = r_tx;
  assign irq_empty = w_empty & (r_state == IDLE);

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: bus writes feed a timing-aware reference
// queue; an independent line monitor decodes frames from tx and checks them.
module tb_bus_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx;
  logic irq_empty;

  bus_uart_tx_if bif();

  bus_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .tx        (tx),
    .irq_empty (irq_empty)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; at a falling edge it names the next edge.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    longint     pop;
    int         len;
  } frame_t;

  frame_t      exp_q[$];
  longint      pops[$];
  int          lens[$];
  int          tests = 0;
  int          fails = 0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_div = 16'd4;
  bit          mon_en = 1'b0;
  longint      p_baud;

  function automatic int div_eff();
    return (m_div == 16'd0) ? 1 : int'(m_div);
  endfunction

  function automatic logic [31:0] to_bus(input logic [31:0] r);
    logic [31:0] b;
    for (int i = 0; i < 4; i++) b[8*(3-i) +: 8] = r[8*i +: 8];
    return b;
  endfunction

  // Bytes accepted but not yet popped just before edge n.
  function automatic int occ_at(input longint n);
    int c = 0;
    foreach (pops[i]) if (pops[i] >= n) c++;
    return c;
  endfunction

  function automatic bit busy_at(input longint n);
    foreach (pops[i]) if (pops[i] <= n - 1 && n - 1 < pops[i] + 10 * lens[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_status(input longint n);
    logic [31:0] s = '0;
    int o = occ_at(n);
    logic [31:0] ov = o;
    s[0]   = (o == DEPTH);
    s[1]   = (o == 0);
    s[2]   = busy_at(n);
    s[3]   = m_ovf;
    s[8:4] = ov[4:0];
    return to_bus(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    pops.delete();
    lens.delete();
    m_ovf = 1'b0;
    m_div = 16'd4;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    longint e;
    longint p;
    @(negedge clk);
    e = cyc;
    bif.mem_address    = a;
    bif.mem_write_data = d;
    bif.byte_mask      = m;
    bif.mem_write      = 1'b1;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0: if (m[3]) begin
          if (occ_at(e) < DEPTH) begin
            p = e + 1;
            if (pops.size() > 0 && pops[$] + 10 * lens[$] + 1 > p) p = pops[$] + 10 * lens[$] + 1;
            exp_q.push_back('{d[31:24], p, div_eff()});
            pops.push_back(p);
            lens.push_back(div_eff());
          end else begin
            m_ovf = 1'b1;
          end
        end
        2'd1: if (m[3] && d[27]) m_ovf = 1'b0;
        2'd2: begin
          if (m[3]) m_div[7:0]  = d[31:24];
          if (m[2]) m_div[15:8] = d[23:16];
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1 bif.mem_write = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [31:0] a, input logic [31:0] exp,
                            input logic exp_sel);
    @(negedge clk);
    bif.mem_address = a;
    bif.mem_write   = 1'b0;
    #1;
    check(name, bif.read_data, exp);
    check({name, "_sel"}, bif.sel, exp_sel);
  endtask

  task automatic check_status(input string name);
    @(negedge clk);
    bif.mem_address = BASE + 32'h4;
    bif.mem_write   = 1'b0;
    #1;
    check(name, bif.read_data, exp_status(cyc));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || (pops.size() > 0 && cyc <= pops[$] + 10 * lens[$] + 2)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", exp_q.size(), n);
    end
  endtask

  // Line monitor: decodes each frame at bit centres and scores it.
  initial begin : monitor
    frame_t     f;
    longint     p;
    int         d;
    logic [9:0] bits;
    bit         have;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        p    = cyc - 1;
        have = (exp_q.size() > 0);
        if (have) begin
          f = exp_q.pop_front();
          d = f.len;
        end else begin
          d = div_eff();
        end
        for (int k = 0; k < 10; k++) begin
          while (cyc < p + 1 + k * d + d / 2) @(negedge clk);
          bits[k] = tx;
        end
        if (!have) begin
          tests++;
          fails++;
          $display("FAIL frame_expected: got frame %h starting at edge %0d, expected none", bits[8:1], p);
        end else begin
          check("frame_byte", {24'h0, bits[8:1]}, {24'h0, f.data});
          check("frame_start_edge", p[31:0], f.pop[31:0]);
          check("frame_start_stop", {30'h0, bits[9], bits[0]}, 32'h2);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] rnd;
    logic [15:0] v;
    longint      tr[16];
    int          ntr;
    int          lows;
    longint      p0;
    int          op;

    bif.mem_address    = '0;
    bif.mem_write_data = '0;
    bif.byte_mask      = '0;
    bif.mem_write      = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx_during", tx, 1'b1);
    reset = 1'b0;
    check("reset_irq_empty", irq_empty, 1'b1);
    check_read("reset_status", BASE + 32'h4, 32'h0200_0000, 1'b1);
    check_read("reset_bauddiv", BASE + 32'h8, 32'h0400_0000, 1'b1);
    check_read("reset_txdata", BASE, 32'h0, 1'b1);
    mon_en = 1'b1;

    // Single frame and its start latency.
    bus_write(BASE, 32'hA512_3456, 4'b1000);
    @(negedge clk);
    check("tx_after_e0", tx, 1'b1);
    @(negedge clk);
    check("tx_after_e1", tx, 1'b0);
    check("irq_during_frame", irq_empty, 1'b0);
    check_status("status_mid_frame");
    drain();
    check("irq_after_frame", irq_empty, 1'b1);

    // Masked-off push, reserved register, out-of-window accesses.
    bus_write(BASE, 32'hFFFF_FFFF, 4'b0001);
    check_read("mask0001_no_push", BASE + 32'h4, 32'h0200_0000, 1'b1);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    check_read("reserved_read", BASE + 32'hC, 32'h0, 1'b1);
    check_read("bauddiv_after_reserved", BASE + 32'h8, 32'h0400_0000, 1'b1);
    check_read("out_of_window", 32'h2000_0008, 32'h0, 1'b0);
    check_read("just_above_window", BASE + 32'h14, 32'h0, 1'b0);

    // Back-to-back burst past capacity.
    for (int i = 0; i < 18; i++) begin
      rnd = $urandom;
      bus_write(BASE, rnd, 4'b1000);
    end
    check_status("burst_status");
    @(negedge clk);
    bif.mem_address = BASE + 32'h4;
    #1;
    check("burst_ovf_full", {30'h0, bif.read_data[27], bif.read_data[24]}, 32'h3);
    bus_write(BASE + 32'h4, 32'h0800_0000, 4'b1000);
    check_status("ovf_cleared");
    drain();
    check_status("burst_drained");

    // Divisor change in the middle of data bit 0.
    mon_en = 1'b0;
    ntr = 0;
    fork
      begin
        bus_write(BASE, 32'h5500_0000, 4'b1000);
        p_baud = pops[$];
        while (cyc < p_baud + 5) @(negedge clk);
        bus_write(BASE + 32'h8, 32'h0800_0000, 4'b1000);
      end
      begin
        logic prev = 1'b1;
        repeat (110) begin
          @(negedge clk);
          if (tx !== prev) begin
            if (ntr < 16) tr[ntr] = cyc - 1;
            ntr++;
            prev = tx;
          end
        end
      end
    join
    check("baud_transitions", ntr, 10);
    for (int k = 0; k < 10 && k < ntr; k++) begin
      check($sformatf("baud_edge_%0d", k), tr[k][31:0],
            (k == 0) ? p_baud[31:0] : (k == 1) ? p_baud[31:0] + 4 : p_baud[31:0] + 8 + (k - 2) * 8);
    end
    check_read("bauddiv_8", BASE + 32'h8, 32'h0800_0000, 1'b1);
    while (cyc < p_baud + 80) @(negedge clk);
    check("irq_after_baud_frame", irq_empty, 1'b1);
    exp_q.delete();
    pops.delete();
    lens.delete();
    bus_write(BASE + 32'h8, 32'h0400_0000, 4'b1100);
    mon_en = 1'b1;

    // Randomised rounds with varying divisor (including zero).
    for (int r = 0; r < 6; r++) begin
      v = 16'($urandom_range(0, 5));
      bus_write(BASE + 32'h8, {v[7:0], v[15:8], 16'h0}, 4'b1100);
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        op  = $urandom_range(0, 9);
        rnd = $urandom;
        if (op < 7) bus_write(BASE, rnd, 4'($urandom_range(0, 15)) | ((op < 5) ? 4'b1000 : 4'b0000));
        else if (op == 7) bus_write(BASE + 32'h4, rnd, 4'($urandom_range(0, 15)));
        else if (op == 8) check_status("rand_status");
        else bus_write(BASE + 32'hC, rnd, 4'b1111);
      end
      check_status("round_status");
      drain();
      check_status("round_drained");
    end

    // Reset in the middle of a frame with another byte queued.
    bus_write(BASE + 32'h8, 32'h0400_0000, 4'b1100);
    bus_write(BASE, 32'h3C00_0000, 4'b1000);
    bus_write(BASE, 32'hC300_0000, 4'b1000);
    mon_en = 1'b0;
    p0 = pops[0];
    while (cyc < p0 + 8) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("reset_mid_tx", tx, 1'b1);
    bif.mem_address = BASE + 32'h4;
    #1 check("reset_mid_status", bif.read_data, 32'h0200_0000);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    mon_en = 1'b1;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("no_residual_frame", lows, 0);
    check_read("status_after_reset", BASE + 32'h4, 32'h0200_0000, 1'b1);
    check("irq_after_reset", irq_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
